aes_key_store: RTL and testbench

- Parametrised round-key generator and store for the iterative AES datapath. Supports AES-128, AES-192 and AES-256 through one parameter.
- Accepts a cipher key over a valid/ready handshake and expands it one 32-bit word per cycle into a register file of NR+1 round keys.
- Serves any round key combinationally to the encrypt and decrypt round blocks.
- Detects resubmission of the stored key and skips re-expansion.

---
 rtl/aes_key_store.sv | 202 ++++++++++++++++++++
 tb/tb_aes_key_store.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_store.sv
// aes_key_store -- AES round-key generator and round-key store.
//
// This block accepts a 128-, 192- or 256-bit cipher key over a valid/ready
// handshake. It then expands the key into NR+1 round keys, one 32-bit word
// per cycle, using the FIPS-197 key schedule. Any round key can be read
// combinationally by the encrypt and decrypt round blocks.
// If the key that was already expanded is submitted again while the store is
// complete, the block reports a hit and does not expand it a second time.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   key_in     cipher key; the most significant 32 bits are word 0
//   key_valid  key_in is presented
//   key_ready  a key can be accepted (IDLE or READY)
//   keys_ok    the store holds the complete expansion of the stored key
//   key_hit    one-cycle pulse after an accepted key matched the stored key
//   busy       expansion in progress
//   rd_round   index of the round key to read, 0..NR
//   rd_key     round key rd_round; all zeros when rd_round > NR

// Forward AES S-box as a constant lookup table. Entry 0 is the leftmost byte.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_byte = SBOX[in_byte];
endmodule

module aes_key_store #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [KEY_BITS-1:0] key_in,
    input  logic                key_valid,
    output logic                key_ready,
    output logic                keys_ok,
    output logic                key_hit,
    output logic                busy,
    input  logic [3:0]          rd_round,
    output logic [127:0]        rd_key
);
    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * NR + 4;
    localparam logic [5:0] NK_W     = 6'(NK);
    localparam logic [5:0] LAST_W   = 6'(NW - 1);
    localparam logic [3:0] NR_W     = 4'(NR);
    localparam logic [2:0] POS_LAST = 3'(NK - 1);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_key_store: KEY_BITS must be 128, 192 or 256");
    end

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        READY
    } state_t;

    state_t              state_q, state_d;
    logic [5:0]          i_q, i_d;        // index of the next word to write
    logic [2:0]          pos_q, pos_d;    // i mod NK, tracked incrementally
    logic [7:0]          rcon_q, rcon_d;  // Rcon for the next i mod NK == 0 word
    logic [KEY_BITS-1:0] key_q, key_d;
    logic                key_hit_q, key_hit_d;
    logic [31:0]         w_q [NW];
    logic [31:0]         w_d [NW];

    logic [31:0] prev_word, back_word, sub_in, sub_out, temp_word, new_word;
    logic [5:0]  rd_base;
    logic        load;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Key-schedule datapath: temp = w[i-1], reshaped by the position rule.
    assign prev_word = w_q[i_q - 6'd1];
    assign back_word = w_q[i_q - NK_W];
    assign sub_in    = (pos_q == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

    for (genvar b = 0; b < 4; b++) begin : g_sub_word
        aes_sbox u_sbox (
            .in_byte  (sub_in[8*b +: 8]),
            .out_byte (sub_out[8*b +: 8])
        );
    end

    always_comb begin
        if (pos_q == 3'd0) begin
            temp_word = sub_out ^ {rcon_q, 24'h000000};
        end else if (NK == 8 && pos_q == 3'd4) begin
            temp_word = sub_out;
        end else begin
            temp_word = prev_word;
        end
        new_word = back_word ^ temp_word;
    end

    // Control: next state and next store contents.
    always_comb begin
        // NOTE: every signal gets a default before the case, so no path leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        i_d       = i_q;
        pos_d     = pos_q;
        rcon_d    = rcon_q;
        key_d     = key_q;
        w_d       = w_q;
        key_hit_d = 1'b0;
        load      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // No hit from IDLE: the stored key is not backed by a valid store.
                load = key_valid;
            end
            READY: begin
                if (key_valid) begin
                    if (key_in == key_q) begin
                        key_hit_d = 1'b1;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            EXPAND: begin
                w_d[i_q] = new_word;
                i_d      = i_q + 6'd1;
                pos_d    = (pos_q == POS_LAST) ? 3'd0 : pos_q + 3'd1;
                if (pos_q == 3'd0) begin
                    rcon_d = xtime(rcon_q);
                end
                if (i_q == LAST_W) begin
                    state_d = READY;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            for (int j = 0; j < NK; j++) begin
                w_d[j] = key_in[KEY_BITS-1-32*j -: 32];
            end
            key_d   = key_in;
            i_d     = NK_W;
            pos_d   = 3'd0;
            rcon_d  = 8'h01;
            state_d = EXPAND;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            i_q       <= '0;
            pos_q     <= '0;
            rcon_q    <= '0;
            key_q     <= '0;
            key_hit_q <= 1'b0;
            // NOTE: the word store is cleared on reset so that an interrupted expansion leaves nothing readable.
            for (int k = 0; k < NW; k++) begin
                w_q[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking updates make every flop see the pre-edge values, the same way the hardware does.
            state_q   <= state_d;
            i_q       <= i_d;
            pos_q     <= pos_d;
            rcon_q    <= rcon_d;
            key_q     <= key_d;
            key_hit_q <= key_hit_d;
            w_q       <= w_d;
        end
    end

    assign key_ready = (state_q != EXPAND);
    assign busy      = (state_q == EXPAND);
    assign keys_ok   = (state_q == READY);
    assign key_hit   = key_hit_q;

    // Round key r is words 4r..4r+3. Word 4r is the most significant.
    always_comb begin
        rd_base = {rd_round, 2'b00};
        rd_key  = '0;
        if (rd_round <= NR_W) begin
            rd_key = {w_q[rd_base], w_q[rd_base + 6'd1], w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]};
        end
    end
endmodule

// File: tb/tb_aes_key_store.sv
// Self-checking bench for aes_key_store. Three instances are used:
// unit 0 is AES-128, unit 1 is AES-192 and unit 2 is AES-256.
// A reference model in the bench expands each key with FIPS-197 arithmetic.
// It builds its S-box from the GF(2^8) inverse followed by the affine map.
// It tracks which words the store holds, one edge at a time.
// A compare process checks every output against the model on every falling edge.
module tb_aes_key_store;
    localparam int NU = 3;

    localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KB     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KB_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [191:0] K2     = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [127:0] K2_R12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [255:0] K3     = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] K3_R1  = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] K3_R14 = 128'hfe4890d1e6188d0b046df344706c631e;

    logic         clk = 1'b0;
    logic         reset;
    logic [255:0] key_a   [NU];
    logic         valid_a [NU];
    logic         ready_a [NU];
    logic         ok_a    [NU];
    logic         hit_a   [NU];
    logic         busy_a  [NU];
    logic [3:0]   rd_a    [NU];
    logic [127:0] rdk_a   [NU];

    always #5 clk = ~clk;

    aes_key_store #(.KEY_BITS(128)) u_dut128 (
        .clk(clk), .reset(reset), .key_in(key_a[0][127:0]), .key_valid(valid_a[0]),
        .key_ready(ready_a[0]), .keys_ok(ok_a[0]), .key_hit(hit_a[0]), .busy(busy_a[0]),
        .rd_round(rd_a[0]), .rd_key(rdk_a[0]));
    aes_key_store #(.KEY_BITS(192)) u_dut192 (
        .clk(clk), .reset(reset), .key_in(key_a[1][191:0]), .key_valid(valid_a[1]),
        .key_ready(ready_a[1]), .keys_ok(ok_a[1]), .key_hit(hit_a[1]), .busy(busy_a[1]),
        .rd_round(rd_a[1]), .rd_key(rdk_a[1]));
    aes_key_store #(.KEY_BITS(256)) u_dut256 (
        .clk(clk), .reset(reset), .key_in(key_a[2]), .key_valid(valid_a[2]),
        .key_ready(ready_a[2]), .keys_ok(ok_a[2]), .key_hit(hit_a[2]), .busy(busy_a[2]),
        .rd_round(rd_a[2]), .rd_key(rdk_a[2]));

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]   sbox_m  [256];
    logic [31:0]  m_new   [NU][60];   // full expansion of the key being loaded
    logic [31:0]  m_store [NU][60];   // what the store must hold right now
    logic [255:0] m_key   [NU];
    int           m_n     [NU];       // words of m_new already in the store
    bit           m_busy  [NU];
    bit           m_ok    [NU];
    bit           m_hit   [NU];

    function automatic logic [7:0] gf_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = gf_xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rol8(input logic [7:0] b, input int s);
        return (b << s) | (b >> (8 - s));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gf_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sbox_m[a] = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox_m[x[31:24]], sbox_m[x[23:16]], sbox_m[x[15:8]], sbox_m[x[7:0]]};
    endfunction

    function automatic logic [7:0] rcon_of(input int k);
        logic [7:0] r;
        r = 8'h01;
        for (int j = 1; j < k; j++) r = gf_xtime(r);
        return r;
    endfunction

    task automatic model_expand(input int u, input logic [255:0] key);
        int nk, nw;
        logic [31:0] t;
        nk = 4 + 2 * u;
        nw = 4 * (nk + 6) + 4;
        for (int j = 0; j < nk; j++) m_new[u][j] = key[(nk - j) * 32 - 1 -: 32];
        for (int i = nk; i < nw; i++) begin
            t = m_new[u][i - 1];
            if (i % nk == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon_of(i / nk), 24'h0};
            else if (nk == 8 && i % nk == 4) t = sub_word(t);
            m_new[u][i] = m_new[u][i - nk] ^ t;
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < NU; u++) begin
            for (int j = 0; j < 60; j++) m_store[u][j] = 32'h0;
            m_key[u]  = '0;
            m_n[u]    = 0;
            m_busy[u] = 1'b0;
            m_ok[u]   = 1'b0;
            m_hit[u]  = 1'b0;
        end
    endtask

    task automatic model_step(input int u);
        int nk, nw;
        nk = 4 + 2 * u;
        nw = 4 * (nk + 6) + 4;
        m_hit[u] = 1'b0;
        if (m_busy[u]) begin
            m_store[u][m_n[u]] = m_new[u][m_n[u]];
            m_n[u]++;
            if (m_n[u] == nw) begin
                m_busy[u] = 1'b0;
                m_ok[u]   = 1'b1;
            end
        end else if (valid_a[u]) begin
            if (m_ok[u] && key_a[u] == m_key[u]) begin
                m_hit[u] = 1'b1;
            end else begin
                model_expand(u, key_a[u]);
                for (int j = 0; j < nk; j++) m_store[u][j] = m_new[u][j];
                m_n[u]    = nk;
                m_key[u]  = key_a[u];
                m_busy[u] = 1'b1;
                m_ok[u]   = 1'b0;
            end
        end
    endtask

    function automatic logic [127:0] exp_rd(input int u, input logic [3:0] r);
        int b;
        if (int'(r) > 4 + 2 * u + 6) return 128'h0;
        b = 4 * int'(r);
        return {m_store[u][b], m_store[u][b + 1], m_store[u][b + 2], m_store[u][b + 3]};
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) model_reset();
        else for (int u = 0; u < NU; u++) model_step(u);
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int u = 0; u < NU; u++) begin
                check($sformatf("u%0d key_ready", u), 128'(ready_a[u]), 128'(!m_busy[u]));
                check($sformatf("u%0d keys_ok", u), 128'(ok_a[u]), 128'(m_ok[u]));
                check($sformatf("u%0d busy", u), 128'(busy_a[u]), 128'(m_busy[u]));
                check($sformatf("u%0d key_hit", u), 128'(hit_a[u]), 128'(m_hit[u]));
                check($sformatf("u%0d rd_key[%0d]", u, rd_a[u]), rdk_a[u], exp_rd(u, rd_a[u]));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input int u, input logic [255:0] k);
        logic rdy;
        int n;
        @(posedge clk); #1;
        key_a[u]   = k;
        valid_a[u] = 1'b1;
        rdy = 1'b0;
        n   = 0;
        while (!rdy && n < 200) begin
            @(negedge clk);
            rdy = ready_a[u];
            @(posedge clk); #1;
            n++;
        end
        valid_a[u] = 1'b0;
        check($sformatf("u%0d key accepted", u), 128'(rdy), 128'd1);
    endtask

    // Counts edges from the acceptance edge (counted as 1) until keys_ok is seen.
    task automatic wait_ok(input int u, input int exp_edges, input string name);
        int n;
        n = 1;
        while (n < 300) begin
            @(negedge clk);
            if (ok_a[u]) break;
            @(posedge clk); #1;
            rd_a[u] = rd_a[u] + 4'd1;
            n++;
        end
        check(name, 128'(n), 128'(exp_edges));
    endtask

    task automatic peek(input int u, input logic [3:0] r, input logic [127:0] exp, input string name);
        @(posedge clk); #1;
        rd_a[u] = r;
        #1;
        check(name, rdk_a[u], exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        for (int u = 0; u < NU; u++) begin
            key_a[u]   = '0;
            valid_a[u] = 1'b0;
            rd_a[u]    = 4'd0;
        end
        build_sbox();
        model_reset();
        check("sbox model 00", 128'(sbox_m[8'h00]), 128'h63);
        check("sbox model 53", 128'(sbox_m[8'h53]), 128'hed);
        #1 reset = 1'b0;
        cmp_en = 1'b1;
        #2;
        check("reset key_ready", 128'(ready_a[0]), 128'd1);
        check("reset keys_ok", 128'(ok_a[0]), 128'd0);
        check("reset busy", 128'(busy_a[0]), 128'd0);
        check("reset key_hit", 128'(hit_a[0]), 128'd0);
        check("reset rd_key", rdk_a[0], 128'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // AES-128 load and latency
        send(0, 256'(K1));
        wait_ok(0, 41, "u0 latency 128");
        peek(0, 4'd1, K1_R1, "u0 round 1");
        peek(0, 4'd10, K1_R10, "u0 round 10");
        peek(0, 4'd0, K1, "u0 round 0");
        peek(0, 4'd11, 128'h0, "u0 round 11 out of range");
        peek(0, 4'd15, 128'h0, "u0 round 15 out of range");

        // AES-192: an all-zero first key gives no hit, then the real key is loaded
        send(1, 256'h0);
        check("u1 zero first key no hit", 128'(hit_a[1]), 128'd0);
        wait_ok(1, 47, "u1 latency zero key");
        send(1, 256'(K2));
        check("u1 new key busy", 128'(busy_a[1]), 128'd1);
        wait_ok(1, 47, "u1 latency 192");
        peek(1, 4'd12, K2_R12, "u1 round 12");
        peek(1, 4'd13, 128'h0, "u1 round 13 out of range");

        // AES-256
        send(2, K3);
        wait_ok(2, 53, "u2 latency 256");
        peek(2, 4'd14, K3_R14, "u2 round 14");
        peek(2, 4'd1, K3_R1, "u2 round 1");
        peek(2, 4'd15, 128'h0, "u2 round 15 out of range");

        // Resubmitting the stored key gives a hit. A new key starts a reload.
        send(0, 256'(K1));
        check("u0 resubmit key_hit", 128'(hit_a[0]), 128'd1);
        check("u0 resubmit busy", 128'(busy_a[0]), 128'd0);
        @(posedge clk); #1;
        check("u0 key_hit one cycle", 128'(hit_a[0]), 128'd0);
        peek(0, 4'd10, K1_R10, "u0 round 10 after hit");
        send(0, 256'(KB));
        check("u0 reload keys_ok", 128'(ok_a[0]), 128'd0);
        check("u0 reload busy", 128'(busy_a[0]), 128'd1);
        wait_ok(0, 41, "u0 latency reload");
        peek(0, 4'd10, KB_R10, "u0 new key round 10");

        // A key held through EXPAND is taken on the first READY cycle
        send(0, 256'(K1));
        key_a[0]   = 256'(KB);
        valid_a[0] = 1'b1;
        n = 1;
        while (n < 300) begin
            @(negedge clk);
            if (ok_a[0]) break;
            @(posedge clk); #1;
            n++;
        end
        check("u0 held key waits for READY", 128'(n), 128'd41);
        @(posedge clk); #1;
        check("u0 held key accepted busy", 128'(busy_a[0]), 128'd1);
        check("u0 held key keys_ok", 128'(ok_a[0]), 128'd0);
        valid_a[0] = 1'b0;
        wait_ok(0, 41, "u0 latency held key");
        peek(0, 4'd10, KB_R10, "u0 held key round 10");

        // Reset between clock edges during expansion cycle 20
        send(0, 256'(K1));
        rd_a[0] = 4'd1;
        repeat (19) @(posedge clk);
        #2;
        check("u0 busy before reset", 128'(busy_a[0]), 128'd1);
        reset = 1'b0;
        #1;
        check("mid reset keys_ok", 128'(ok_a[0]), 128'd0);
        check("mid reset busy", 128'(busy_a[0]), 128'd0);
        check("mid reset key_ready", 128'(ready_a[0]), 128'd1);
        check("mid reset rd_key", rdk_a[0], 128'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        send(0, 256'(K1));
        wait_ok(0, 41, "u0 latency after reset");
        peek(0, 4'd1, K1_R1, "u0 round 1 after reset");
        peek(0, 4'd10, K1_R10, "u0 round 10 after reset");

        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
